// File: rtl/csr_pkg.sv
// Shared CSR addresses, trap cause codes and enums for the machine-mode CSR/trap block.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    localparam logic [31:0] CAUSE_ILLEGAL   = 32'h0000_0002;
    localparam logic [31:0] CAUSE_ECALL     = 32'h0000_000B;
    localparam logic [31:0] CAUSE_EXT_IRQ   = 32'h8000_000B;
    localparam logic [31:0] CAUSE_TIMER_IRQ = 32'h8000_0007;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_SAVE,
        ST_REDIRECT,
        ST_RET
    } trap_state_e;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RW   = 2'b01,
        OP_RS   = 2'b10,
        OP_RC   = 2'b11
    } csr_op_e;

endpackage

// File: rtl/csr_regfile.sv
// Machine-mode CSR storage, read mux, read-modify-write ops and the 64-bit cycle counter.
// Trap save and mret updates arrive only outside IDLE, so they never collide with software writes.
module csr_regfile
    import csr_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_MTVEC = '0,
    parameter int unsigned     HART_ID     = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_wr_en,
    input  csr_op_e         i_op,
    input  logic [11:0]     i_addr,
    input  logic [XLEN-1:0] i_wdata,
    output logic [XLEN-1:0] o_rdata,
    input  logic            i_save_en,
    input  logic [XLEN-3:0] i_save_pc,
    input  logic [XLEN-1:0] i_save_cause,
    input  logic            i_mret_en,
    input  logic            i_ext_irq,
    input  logic            i_timer_irq,
    output logic [XLEN-1:0] o_mtvec,
    output logic [XLEN-1:0] o_mepc,
    output logic            o_ext_pend,
    output logic            o_tmr_pend
);

    logic            r_mie_bit;
    logic            r_mpie;
    logic            r_meie;
    logic            r_mtie;
    logic [XLEN-3:0] r_mtvec;
    logic [XLEN-3:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mscratch;
    logic [63:0]     r_mcycle;

    logic [XLEN-1:0] w_mstatus;
    logic [XLEN-1:0] w_mie;
    logic [XLEN-1:0] w_mip;
    logic [XLEN-1:0] w_old;
    logic [XLEN-1:0] w_new;
    logic            w_we;

    always_comb begin
        w_mstatus        = '0;
        w_mstatus[12:11] = 2'b11;
        w_mstatus[7]     = r_mpie;
        w_mstatus[3]     = r_mie_bit;
        w_mie            = '0;
        w_mie[11]        = r_meie;
        w_mie[7]         = r_mtie;
        w_mip            = '0;
        w_mip[11]        = i_ext_irq;
        w_mip[7]         = i_timer_irq;
    end

    always_comb begin
        case (i_addr)
            CSR_MSTATUS:  w_old = w_mstatus;
            CSR_MIE:      w_old = w_mie;
            CSR_MIP:      w_old = w_mip;
            CSR_MTVEC:    w_old = {r_mtvec, 2'b00};
            CSR_MEPC:     w_old = {r_mepc, 2'b00};
            CSR_MCAUSE:   w_old = r_mcause;
            CSR_MSCRATCH: w_old = r_mscratch;
            CSR_MCYCLE:   w_old = XLEN'(r_mcycle[31:0]);
            CSR_MCYCLEH:  w_old = XLEN'(r_mcycle[63:32]);
            CSR_MHARTID:  w_old = XLEN'(HART_ID);
            default:      w_old = '0;
        endcase
    end

    always_comb begin
        case (i_op)
            OP_RW:   w_new = i_wdata;
            OP_RS:   w_new = w_old | i_wdata;
            OP_RC:   w_new = w_old & ~i_wdata;
            default: w_new = w_old;
        endcase
    end

    // Set/clear with a zero mask must not write (no side effects on read-only CSRs)
    assign w_we = i_wr_en && ((i_op == OP_RW) ||
                  (((i_op == OP_RS) || (i_op == OP_RC)) && (i_wdata != '0)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mie_bit  <= 1'b0;
            r_mpie     <= 1'b0;
            r_meie     <= 1'b0;
            r_mtie     <= 1'b0;
            r_mtvec    <= RESET_MTVEC[XLEN-1:2];
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mscratch <= '0;
        end else if (i_save_en) begin
            r_mepc    <= i_save_pc;
            r_mcause  <= i_save_cause;
            r_mpie    <= r_mie_bit;
            r_mie_bit <= 1'b0;
        end else if (i_mret_en) begin
            r_mie_bit <= r_mpie;
            r_mpie    <= 1'b1;
        end else if (w_we) begin
            case (i_addr)
                CSR_MSTATUS: begin
                    r_mie_bit <= w_new[3];
                    r_mpie    <= w_new[7];
                end
                CSR_MIE: begin
                    r_meie <= w_new[11];
                    r_mtie <= w_new[7];
                end
                CSR_MTVEC:    r_mtvec    <= w_new[XLEN-1:2];
                CSR_MEPC:     r_mepc     <= w_new[XLEN-1:2];
                CSR_MCAUSE:   r_mcause   <= w_new;
                CSR_MSCRATCH: r_mscratch <= w_new;
                default: ;
            endcase
        end
    end

    // A software write replaces the increment for that cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcycle <= '0;
        end else if (w_we && (i_addr == CSR_MCYCLE)) begin
            r_mcycle[31:0] <= w_new[31:0];
        end else if (w_we && (i_addr == CSR_MCYCLEH)) begin
            r_mcycle[63:32] <= w_new[31:0];
        end else begin
            r_mcycle <= r_mcycle + 64'd1;
        end
    end

    assign o_rdata    = w_old;
    assign o_mtvec    = {r_mtvec, 2'b00};
    assign o_mepc     = {r_mepc, 2'b00};
    assign o_ext_pend = r_mie_bit & r_meie & i_ext_irq;
    assign o_tmr_pend = r_mie_bit & r_mtie & i_timer_irq;

endmodule

// File: rtl/csr_trap_unit.sv
// CSR file plus trap sequencer: drains the pipe, saves mepc/mcause, redirects fetch to mtvec or mepc.
// Exception entry redirects 3 cycles after detection (pipe idle); mret redirects 1 cycle after.
module csr_trap_unit
    import csr_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_MTVEC = 32'h0000_0000,
    parameter int unsigned     HART_ID     = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            csr_write_i,
    input  logic [2:0]      csr_func3_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic [XLEN-1:0] csr_rdata_o,
    input  logic            ecall_i,
    input  logic            illegal_i,
    input  logic            mret_i,
    input  logic [XLEN-1:0] exc_pc_i,
    input  logic [XLEN-1:0] next_pc_i,
    input  logic            ext_irq_i,
    input  logic            timer_irq_i,
    input  logic            pipe_idle_i,
    output logic            stall_o,
    output logic            flush_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o
);

    trap_state_e     r_state;
    logic            r_stall;
    logic            r_flush;
    logic            r_redirect;
    logic [XLEN-3:0] r_trap_pc;
    logic [XLEN-1:0] r_trap_cause;

    logic            w_idle;
    logic            w_ext_pend;
    logic            w_tmr_pend;
    logic            w_trap;
    logic            w_wr_en;
    logic [XLEN-3:0] w_pc;
    logic [XLEN-1:0] w_cause;
    logic [XLEN-1:0] w_mtvec;
    logic [XLEN-1:0] w_mepc;
    logic [4:0]      w_unused_bits;

    // The immediate flag only steers the operand mux upstream; PCs are word aligned
    assign w_unused_bits = {csr_func3_i[2], exc_pc_i[1:0], next_pc_i[1:0]};

    assign w_idle  = (r_state == ST_IDLE);
    assign w_trap  = w_idle & (illegal_i | ecall_i | w_ext_pend | w_tmr_pend);
    assign w_wr_en = csr_write_i & w_idle & ~w_trap;

    always_comb begin
        w_cause = XLEN'(CAUSE_TIMER_IRQ);
        w_pc    = next_pc_i[XLEN-1:2];
        if (illegal_i) begin
            w_cause = XLEN'(CAUSE_ILLEGAL);
            w_pc    = exc_pc_i[XLEN-1:2];
        end else if (ecall_i) begin
            w_cause = XLEN'(CAUSE_ECALL);
            w_pc    = exc_pc_i[XLEN-1:2];
        end else if (w_ext_pend) begin
            w_cause = XLEN'(CAUSE_EXT_IRQ);
        end
    end

    csr_regfile #(
        .XLEN        (XLEN),
        .RESET_MTVEC (RESET_MTVEC),
        .HART_ID     (HART_ID)
    ) u_regfile (
        .clk          (clk),
        .reset        (reset),
        .i_wr_en      (w_wr_en),
        .i_op         (csr_op_e'(csr_func3_i[1:0])),
        .i_addr       (csr_addr_i),
        .i_wdata      (csr_wdata_i),
        .o_rdata      (csr_rdata_o),
        .i_save_en    (r_state == ST_SAVE),
        .i_save_pc    (r_trap_pc),
        .i_save_cause (r_trap_cause),
        .i_mret_en    (r_state == ST_RET),
        .i_ext_irq    (ext_irq_i),
        .i_timer_irq  (timer_irq_i),
        .o_mtvec      (w_mtvec),
        .o_mepc       (w_mepc),
        .o_ext_pend   (w_ext_pend),
        .o_tmr_pend   (w_tmr_pend)
    );

    // Outputs are registered against the state being entered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_stall      <= 1'b0;
            r_flush      <= 1'b0;
            r_redirect   <= 1'b0;
            r_trap_pc    <= '0;
            r_trap_cause <= '0;
        end else begin
            r_stall    <= 1'b0;
            r_flush    <= 1'b0;
            r_redirect <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_trap) begin
                        r_state      <= ST_DRAIN;
                        r_stall      <= 1'b1;
                        r_trap_pc    <= w_pc;
                        r_trap_cause <= w_cause;
                    end else if (mret_i) begin
                        r_state    <= ST_RET;
                        r_flush    <= 1'b1;
                        r_redirect <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    r_stall <= 1'b1;
                    if (pipe_idle_i) begin
                        r_state <= ST_SAVE;
                    end
                end
                ST_SAVE: begin
                    r_state    <= ST_REDIRECT;
                    r_stall    <= 1'b1;
                    r_flush    <= 1'b1;
                    r_redirect <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign stall_o       = r_stall;
    assign flush_o       = r_flush;
    assign redirect_o    = r_redirect;
    assign redirect_pc_o = (r_state == ST_REDIRECT) ? w_mtvec :
                           (r_state == ST_RET)      ? w_mepc  : '0;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Scoreboard bench for csr_trap_unit: stimulus pushes expectations, a negedge monitor pops and compares.
module tb_csr_trap_unit;
    import csr_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        csr_write_i = 1'b0;
    logic [2:0]  csr_func3_i = 3'b000;
    logic [11:0] csr_addr_i = 12'h000;
    logic [31:0] csr_wdata_i = 32'h0;
    logic [31:0] csr_rdata_o;
    logic        ecall_i = 1'b0;
    logic        illegal_i = 1'b0;
    logic        mret_i = 1'b0;
    logic [31:0] exc_pc_i = 32'h0;
    logic [31:0] next_pc_i = 32'h0;
    logic        ext_irq_i = 1'b0;
    logic        timer_irq_i = 1'b0;
    logic        pipe_idle_i = 1'b1;
    logic        stall_o;
    logic        flush_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;

    typedef struct packed { logic [11:0] addr; logic [31:0] data; } rd_t;
    typedef struct packed { logic stall; logic flush; logic redir; logic [31:0] pc; } st_t;
    typedef struct packed { logic [31:0] pc; logic [31:0] cyc; } rx_t;

    rd_t rd_q[$];
    st_t st_q[$];
    rx_t rx_q[$];

    logic        rd_probe = 1'b0;
    logic        st_probe = 1'b0;
    logic [31:0] cyc = 32'd0;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    csr_trap_unit #(
        .XLEN        (32),
        .RESET_MTVEC (32'h0000_0000),
        .HART_ID     (0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .csr_write_i   (csr_write_i),
        .csr_func3_i   (csr_func3_i),
        .csr_addr_i    (csr_addr_i),
        .csr_wdata_i   (csr_wdata_i),
        .csr_rdata_o   (csr_rdata_o),
        .ecall_i       (ecall_i),
        .illegal_i     (illegal_i),
        .mret_i        (mret_i),
        .exc_pc_i      (exc_pc_i),
        .next_pc_i     (next_pc_i),
        .ext_irq_i     (ext_irq_i),
        .timer_irq_i   (timer_irq_i),
        .pipe_idle_i   (pipe_idle_i),
        .stall_o       (stall_o),
        .flush_o       (flush_o),
        .redirect_o    (redirect_o),
        .redirect_pc_o (redirect_pc_o)
    );

    always @(negedge clk) begin
        if (rd_probe) begin
            rd_t e;
            tests++;
            if (rd_q.size() == 0) begin
                fails++;
                $display("FAIL rdata: probe with empty queue at cycle %0d", cyc);
            end else begin
                e = rd_q.pop_front();
                if (csr_rdata_o !== e.data) begin
                    fails++;
                    $display("FAIL rdata addr=%h cycle=%0d: got %h want %h", e.addr, cyc, csr_rdata_o, e.data);
                end
            end
        end
        if (st_probe) begin
            st_t s;
            tests++;
            if (st_q.size() == 0) begin
                fails++;
                $display("FAIL status: probe with empty queue at cycle %0d", cyc);
            end else begin
                s = st_q.pop_front();
                if ({stall_o, flush_o, redirect_o, redirect_pc_o} !== {s.stall, s.flush, s.redir, s.pc}) begin
                    fails++;
                    $display("FAIL status cycle=%0d: got stall/flush/redir=%b%b%b pc=%h want %b%b%b pc=%h",
                             cyc, stall_o, flush_o, redirect_o, redirect_pc_o, s.stall, s.flush, s.redir, s.pc);
                end
            end
        end
        if (redirect_o === 1'b1) begin
            rx_t r;
            tests++;
            if (rx_q.size() == 0) begin
                fails++;
                $display("FAIL redirect: unexpected redirect pc=%h at cycle %0d", redirect_pc_o, cyc);
            end else begin
                r = rx_q.pop_front();
                if (redirect_pc_o !== r.pc || cyc !== r.cyc) begin
                    fails++;
                    $display("FAIL redirect: got pc=%h cycle=%0d want pc=%h cycle=%0d", redirect_pc_o, cyc, r.pc, r.cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        csr_write_i = 1'b0;
        ecall_i     = 1'b0;
        illegal_i   = 1'b0;
        mret_i      = 1'b0;
        rd_probe    = 1'b0;
        st_probe    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic csr_wr(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] wd);
        step();
        csr_write_i = 1'b1;
        csr_func3_i = f3;
        csr_addr_i  = a;
        csr_wdata_i = wd;
    endtask

    task automatic csr_op(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_old);
        csr_wr(f3, a, wd);
        rd_probe = 1'b1;
        rd_q.push_back('{addr: a, data: exp_old});
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp_val);
        step();
        csr_addr_i = a;
        rd_probe   = 1'b1;
        rd_q.push_back('{addr: a, data: exp_val});
    endtask

    task automatic st_now(input logic s, input logic f, input logic r, input logic [31:0] pc);
        st_probe = 1'b1;
        st_q.push_back('{stall: s, flush: f, redir: r, pc: pc});
    endtask

    task automatic st(input logic s, input logic f, input logic r, input logic [31:0] pc);
        step();
        st_now(s, f, r, pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        st_now(1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        st_probe = 1'b0;
        rd(CSR_MSTATUS, 32'h0000_1800);
        rd(CSR_MTVEC,   32'h0);
        rd(CSR_MIE,     32'h0);
        rd(CSR_MHARTID, 32'h0);
        rd(CSR_MCYCLEH, 32'h0);
        csr_op(3'b001, 12'h7C0, 32'hDEAD, 32'h0);
        rd(12'h7C0, 32'h0);
        rd(CSR_MIP, 32'h0000_0800);
        ext_irq_i = 1'b1;
        step();
        ext_irq_i = 1'b0;

        // CSR read-modify-write
        csr_op(3'b001, CSR_MTVEC, 32'h0000_0103, 32'h0);
        rd(CSR_MTVEC, 32'h0000_0100);
        csr_op(3'b001, CSR_MSCRATCH, 32'h0000_000F, 32'h0);
        csr_op(3'b010, CSR_MSCRATCH, 32'h0000_00F0, 32'h0000_000F);
        rd(CSR_MSCRATCH, 32'h0000_00FF);
        csr_op(3'b110, CSR_MSTATUS, 32'h0000_0008, 32'h0000_1800);

        // ecall with idle pipe
        step();
        ecall_i     = 1'b1;
        exc_pc_i    = 32'h0000_0040;
        pipe_idle_i = 1'b1;
        rx_q.push_back('{pc: 32'h0000_0100, cyc: cyc + 32'd3});
        st(1'b1, 1'b0, 1'b0, 32'h0);
        st(1'b1, 1'b0, 1'b0, 32'h0);
        st(1'b1, 1'b1, 1'b1, 32'h0000_0100);
        step();
        rd(CSR_MEPC,    32'h0000_0040);
        rd(CSR_MCAUSE,  32'h0000_000B);
        rd(CSR_MSTATUS, 32'h0000_1880);

        // Timer interrupt with the pipe busy for 4 cycles
        csr_op(3'b010, CSR_MSTATUS, 32'h0000_0008, 32'h0000_1880);
        csr_op(3'b010, CSR_MIE,     32'h0000_0080, 32'h0);
        step();
        timer_irq_i = 1'b1;
        next_pc_i   = 32'h0000_0088;
        pipe_idle_i = 1'b0;
        rx_q.push_back('{pc: 32'h0000_0100, cyc: cyc + 32'd7});
        st(1'b1, 1'b0, 1'b0, 32'h0);
        timer_irq_i = 1'b0;
        st(1'b1, 1'b0, 1'b0, 32'h0);
        st(1'b1, 1'b0, 1'b0, 32'h0);
        st(1'b1, 1'b0, 1'b0, 32'h0);
        step();
        pipe_idle_i = 1'b1;
        st(1'b1, 1'b0, 1'b0, 32'h0);
        st(1'b1, 1'b1, 1'b1, 32'h0000_0100);
        step();
        rd(CSR_MCAUSE,  32'h8000_0007);
        rd(CSR_MEPC,    32'h0000_0088);
        rd(CSR_MSTATUS, 32'h0000_1880);

        // External and timer together, CSR write in the same cycle is dropped
        csr_op(3'b010, CSR_MSTATUS, 32'h0000_0008, 32'h0000_1880);
        csr_op(3'b010, CSR_MIE,     32'h0000_0800, 32'h0000_0080);
        csr_op(3'b001, CSR_MSCRATCH, 32'h0000_1234, 32'h0000_00FF);
        ext_irq_i   = 1'b1;
        timer_irq_i = 1'b1;
        next_pc_i   = 32'h0000_00C0;
        rx_q.push_back('{pc: 32'h0000_0100, cyc: cyc + 32'd3});
        step();
        ext_irq_i   = 1'b0;
        timer_irq_i = 1'b0;
        idle(3);
        rd(CSR_MCAUSE,   32'h8000_000B);
        rd(CSR_MSCRATCH, 32'h0000_00FF);
        rd(CSR_MEPC,     32'h0000_00C0);
        csr_op(3'b011, CSR_MSCRATCH, 32'h0000_000F, 32'h0000_00FF);
        rd(CSR_MSCRATCH, 32'h0000_00F0);

        // mret
        csr_op(3'b001, CSR_MEPC, 32'h0000_0200, 32'h0000_00C0);
        rd(CSR_MSTATUS, 32'h0000_1880);
        step();
        mret_i = 1'b1;
        rx_q.push_back('{pc: 32'h0000_0200, cyc: cyc + 32'd1});
        st(1'b0, 1'b1, 1'b1, 32'h0000_0200);
        step();
        rd(CSR_MSTATUS, 32'h0000_1888);

        // illegal outranks ecall
        step();
        illegal_i = 1'b1;
        ecall_i   = 1'b1;
        exc_pc_i  = 32'h0000_0044;
        rx_q.push_back('{pc: 32'h0000_0100, cyc: cyc + 32'd3});
        idle(4);
        rd(CSR_MCAUSE,  32'h0000_0002);
        rd(CSR_MEPC,    32'h0000_0044);
        rd(CSR_MSTATUS, 32'h0000_1880);

        // Reset in SAVE, then mcycle carry into mcycleh
        step();
        ecall_i  = 1'b1;
        exc_pc_i = 32'h0000_0300;
        step();
        step();
        reset = 1'b1;
        st_now(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        reset = 1'b0;
        rd(CSR_MEPC,    32'h0);
        rd(CSR_MCAUSE,  32'h0);
        rd(CSR_MSTATUS, 32'h0000_1800);
        csr_wr(3'b001, CSR_MCYCLE, 32'hFFFF_FFFF);
        rd(CSR_MCYCLE,  32'hFFFF_FFFF);
        rd(CSR_MCYCLE,  32'h0);
        rd(CSR_MCYCLEH, 32'h0000_0001);
        idle(4);

        tests++;
        if (rd_q.size() != 0 || st_q.size() != 0 || rx_q.size() != 0) begin
            fails++;
            $display("FAIL drain: leftover rd=%0d st=%0d redirect=%0d want 0 0 0",
                     rd_q.size(), st_q.size(), rx_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
